// File: rtl/cybercobra_mc.sv
// CYBERCOBRA multicycle core: FETCH/EXEC/HALT sequencer around a 32x32 register file,
// alu_riscv, a synchronous-read instruction memory port and valid/ready I/O channels.

module alu_riscv (
  input  logic [4:0]  alu_op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        flag_o
);
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b01000;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_AND  = 5'b00111;
  localparam logic [4:0] ALU_SRA  = 5'b01101;
  localparam logic [4:0] ALU_SRL  = 5'b00101;
  localparam logic [4:0] ALU_SLL  = 5'b00001;
  localparam logic [4:0] ALU_LTS  = 5'b11100;
  localparam logic [4:0] ALU_LTU  = 5'b11110;
  localparam logic [4:0] ALU_GES  = 5'b11101;
  localparam logic [4:0] ALU_GEU  = 5'b11111;
  localparam logic [4:0] ALU_EQ   = 5'b11000;
  localparam logic [4:0] ALU_NE   = 5'b11001;
  localparam logic [4:0] ALU_SLTS = 5'b00010;
  localparam logic [4:0] ALU_SLTU = 5'b00011;

  always_comb begin
    result_o = 32'd0;
    flag_o   = 1'b0;
    case (alu_op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
      ALU_SRL:  result_o = a_i >> b_i[4:0];
      ALU_SLL:  result_o = a_i << b_i[4:0];
      ALU_SLTS: result_o = {31'd0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {31'd0, a_i < b_i};
      ALU_LTS:  flag_o = $signed(a_i) < $signed(b_i);
      ALU_LTU:  flag_o = a_i < b_i;
      ALU_GES:  flag_o = $signed(a_i) >= $signed(b_i);
      ALU_GEU:  flag_o = a_i >= b_i;
      ALU_EQ:   flag_o = a_i == b_i;
      ALU_NE:   flag_o = a_i != b_i;
      default:  ;
    endcase
  end
endmodule

module cybercobra_mc #(
  parameter int IN_W   = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_rdata_i,
  input  logic [IN_W-1:0]   in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [31:0]       out_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              halted_o
);
  localparam int PC_W = ADDR_W + 2;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     rf_q [32];

  logic        instr_j, instr_b;
  logic [1:0]  instr_ws;
  logic [4:0]  alu_op, ra1, ra2, wa;
  logic [7:0]  offs;
  logic [31:0] const_val, rd1, rd2, in_sext, alu_result;
  logic        alu_flag;
  logic        rf_we;
  logic [31:0] rf_wd;
  logic [PC_W-1:0] pc_plus4, pc_target;

  assign instr_j   = imem_rdata_i[31];
  assign instr_b   = imem_rdata_i[30];
  assign instr_ws  = imem_rdata_i[29:28];
  assign alu_op    = imem_rdata_i[27:23];
  assign ra1       = imem_rdata_i[22:18];
  assign ra2       = imem_rdata_i[17:13];
  assign offs      = imem_rdata_i[12:5];
  assign wa        = imem_rdata_i[4:0];
  assign const_val = 32'($signed(imem_rdata_i[27:5]));
  assign in_sext   = 32'($signed(in_data_i));

  // x0 is never written, so its storage is ignored on read
  assign rd1 = (ra1 == 5'd0) ? 32'd0 : rf_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : rf_q[ra2];

  alu_riscv u_alu (
    .alu_op_i (alu_op),
    .a_i      (rd1),
    .b_i      (rd2),
    .result_o (alu_result),
    .flag_o   (alu_flag)
  );

  assign pc_plus4  = pc_q + PC_W'(4);
  assign pc_target = pc_q + PC_W'($signed({offs, 2'b00}));

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    rf_we       = 1'b0;
    rf_wd       = 32'd0;
    in_ready_o  = 1'b0;
    // the output channel drains in every state, including HALT
    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        if (instr_j && (offs == 8'd0)) begin
          state_d = S_HALT;
        end else if (instr_j || instr_b) begin
          pc_d    = (instr_j || alu_flag) ? pc_target : pc_plus4;
          state_d = S_FETCH;
        end else begin
          case (instr_ws)
            2'd0: begin
              rf_we   = 1'b1;
              rf_wd   = const_val;
              pc_d    = pc_plus4;
              state_d = S_FETCH;
            end
            2'd1: begin
              rf_we   = 1'b1;
              rf_wd   = alu_result;
              pc_d    = pc_plus4;
              state_d = S_FETCH;
            end
            2'd2: begin
              in_ready_o = 1'b1;
              if (in_valid_i) begin
                rf_we   = 1'b1;
                rf_wd   = in_sext;
                pc_d    = pc_plus4;
                state_d = S_FETCH;
              end
            end
            default: begin
              if (!out_valid_q || out_ready_i) begin
                out_d       = rd1;
                out_valid_d = 1'b1;
                pc_d        = pc_plus4;
                state_d     = S_FETCH;
              end
            end
          endcase
        end
      end
      S_HALT:  ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      out_q       <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // reset wins over a pending writeback, but the array itself is never cleared
  always_ff @(posedge clk_i) begin
    if (!rst_i && rf_we && (wa != 5'd0)) begin
      rf_q[wa] <= rf_wd;
    end
  end

  assign imem_addr_o = pc_q[PC_W-1:2];
  assign out_o       = out_q;
  assign out_valid_o = out_valid_q;
  assign halted_o    = (state_q == S_HALT);
endmodule

// File: tb/tb_cybercobra_mc.sv
// Bench for cybercobra_mc: directed corner sequences, an ALU vector table run as tiny
// programs, and random programs checked against an instruction-level reference model.

module tb_cybercobra_mc;
  localparam int IN_W   = 16;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_rdata_i;
  logic [IN_W-1:0]   in_data_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [31:0]       out_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic              halted_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]     mem [256];
  logic [31:0]     got_q [$];
  logic [31:0]     exp_q [$];
  logic [IN_W-1:0] in_q  [$];
  bit              auto_drv = 1'b0;

  cybercobra_mc #(.IN_W(IN_W), .ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata_i),
    .in_data_i    (in_data_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .out_o        (out_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .halted_o     (halted_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata_i <= mem[imem_addr_o];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  function automatic logic [31:0] e_const(input logic [4:0] wa, input logic [31:0] c);
    return {4'b0000, c[22:0], wa};
  endfunction
  function automatic logic [31:0] e_alu(input logic [4:0] op, input logic [4:0] a,
                                        input logic [4:0] b, input logic [4:0] wa);
    return {4'b0001, op, a, b, 8'h00, wa};
  endfunction
  function automatic logic [31:0] e_in(input logic [4:0] wa);
    return {4'b0010, 23'd0, wa};
  endfunction
  function automatic logic [31:0] e_out(input logic [4:0] ra);
    return {4'b0011, 5'd0, ra, 18'd0};
  endfunction
  function automatic logic [31:0] e_br(input logic [4:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [7:0] offs);
    return {4'b0100, op, a, b, offs, 5'd0};
  endfunction
  function automatic logic [31:0] e_jmp(input logic [7:0] offs);
    return {4'b1000, 15'd0, offs, 5'd0};
  endfunction

  // Reference ALU written from the operation definitions
  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      5'b00000: return a + b;
      5'b01000: return a - b;
      5'b00100: return a ^ b;
      5'b00110: return a | b;
      5'b00111: return a & b;
      5'b00001: return a << sh;
      5'b00101: return a >> sh;
      5'b01101: return 32'(longint'($signed(a)) / (longint'(1) << sh)) - 32'((($signed(a) < 0) && ((a & ((32'd1 << sh) - 1)) != 0)) ? 1 : 0);
      5'b00010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'b00011: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction
  function automatic bit ref_flag(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'b11000: return a == b;
      5'b11001: return a != b;
      5'b11100: return $signed(a) < $signed(b);
      5'b11101: return $signed(a) >= $signed(b);
      5'b11110: return a < b;
      5'b11111: return a >= b;
      default:  return 1'b0;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h8000_0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    step(2);
    rst_i = 1'b0;
  endtask

  // Random handshake driver plus recorder of completed transfers on both channels
  initial begin
    logic [31:0] rnd;
    forever begin
      @(negedge clk);
      if (auto_drv) begin
        rnd         = $urandom;
        out_ready_i = rnd[0] | rnd[1];
        in_valid_i  = rnd[2] & rnd[3];
        in_data_i   = rnd[31:16];
      end
      if (out_valid_o && out_ready_i) got_q.push_back(out_o);
      if (in_valid_i && in_ready_o) in_q.push_back(in_data_i);
    end
  end

  task automatic run_prog(input string name, input int halt_idx);
    int cyc;
    auto_drv = 1'b1;
    do_reset();
    got_q.delete();
    in_q.delete();
    cyc = 0;
    while (!halted_o && cyc < 3000) begin step(1); cyc++; end
    while (out_valid_o && cyc < 3200) begin step(1); cyc++; end
    check({name, " done"}, 32'(halted_o & ~out_valid_o), 32'd1);
    check({name, " halt addr"}, 32'(imem_addr_o), 32'(halt_idx));
    auto_drv    = 1'b0;
    out_ready_i = 1'b0;
    in_valid_i  = 1'b0;
  endtask

  // Instruction-level interpreter over mem[], consuming recorded inputs in order
  task automatic model_run(output int used_in);
    logic [31:0] r [32];
    logic [31:0] ins, a, b, wd;
    int pc, k;
    bit wr;
    for (int i = 0; i < 32; i++) r[i] = 32'd0;
    exp_q.delete();
    pc = 0;
    k  = 0;
    for (int s = 0; s < 1000; s++) begin
      ins = mem[pc];
      a   = r[ins[22:18]];
      b   = r[ins[17:13]];
      if (ins[31] && ins[12:5] == 8'd0) break;
      if (ins[31] || ins[30]) begin
        if (ins[31] || ref_flag(ins[27:23], a, b)) pc = (pc + int'($signed(ins[12:5]))) & 255;
        else pc = (pc + 1) & 255;
      end else begin
        wr = 1'b1;
        wd = 32'd0;
        case (ins[29:28])
          2'd0: wd = 32'($signed(ins[27:5]));
          2'd1: wd = ref_res(ins[27:23], a, b);
          2'd2: begin
            if (k < in_q.size()) wd = 32'($signed(in_q[k]));
            k++;
          end
          default: begin
            wr = 1'b0;
            exp_q.push_back(a);
          end
        endcase
        if (wr && ins[4:0] != 5'd0) r[ins[4:0]] = wd;
        pc = (pc + 1) & 255;
      end
    end
    used_in = k;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        flag;
    string       name;
  } alu_vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_vec_t    vt [17];
    logic [4:0]  ops [16];
    logic [31:0] prog_word;
    int          idx, bad, used_in, nmin;

    vt[0]  = '{5'b00000, 32'd5,         32'd7,  32'd12,        1'b0, "add"};
    vt[1]  = '{5'b00000, 32'hFFFFFFFD,  32'd1,  32'hFFFFFFFE,  1'b0, "add neg"};
    vt[2]  = '{5'b01000, 32'd5,         32'd7,  32'hFFFFFFFE,  1'b0, "sub"};
    vt[3]  = '{5'b00100, 32'h0F0F,      32'h00FF, 32'h0FF0,    1'b0, "xor"};
    vt[4]  = '{5'b00110, 32'h0F00,      32'h00F0, 32'h0FF0,    1'b0, "or"};
    vt[5]  = '{5'b00111, 32'h0FF0,      32'h00FF, 32'h00F0,    1'b0, "and"};
    vt[6]  = '{5'b00001, 32'd1,         32'd35, 32'd8,         1'b0, "sll"};
    vt[7]  = '{5'b00101, 32'hFFFFFFF0,  32'd4,  32'h0FFFFFFF,  1'b0, "srl"};
    vt[8]  = '{5'b01101, 32'hFFFFFFF0,  32'd4,  32'hFFFFFFFF,  1'b0, "sra"};
    vt[9]  = '{5'b00010, 32'hFFFFFFFF,  32'd1,  32'd1,         1'b0, "slts"};
    vt[10] = '{5'b00011, 32'hFFFFFFFF,  32'd1,  32'd0,         1'b0, "sltu"};
    vt[11] = '{5'b11100, 32'hFFFFFFFF,  32'd1,  32'd0,         1'b1, "lts"};
    vt[12] = '{5'b11110, 32'hFFFFFFFF,  32'd1,  32'd0,         1'b0, "ltu"};
    vt[13] = '{5'b11101, 32'd3,         32'd3,  32'd0,         1'b1, "ges"};
    vt[14] = '{5'b11111, 32'd1,         32'hFFFFFFFF, 32'd0,   1'b0, "geu"};
    vt[15] = '{5'b11000, 32'd4,         32'd4,  32'd0,         1'b1, "eq"};
    vt[16] = '{5'b11001, 32'd4,         32'd4,  32'd0,         1'b0, "ne"};
    for (int i = 0; i < 16; i++) ops[i] = (i < 11) ? vt[i < 6 ? i : i - 0].op : 5'd0;
    ops = '{5'b00000, 5'b01000, 5'b00100, 5'b00110, 5'b00111, 5'b00001, 5'b00101, 5'b01101,
            5'b00010, 5'b00011, 5'b11100, 5'b11101, 5'b11110, 5'b11111, 5'b11000, 5'b11001};

    rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    clear_mem();

    // reset state
    do_reset();
    check("reset out_o", out_o, 32'd0);
    check("reset out_valid", 32'(out_valid_o), 32'd0);
    check("reset halted", 32'(halted_o), 32'd0);
    check("reset in_ready", 32'(in_ready_o), 32'd0);
    check("reset addr", 32'(imem_addr_o), 32'd0);

    // constant load then OUTPUT, visible after the fourth edge
    mem[0] = 32'h000000A1;
    mem[1] = 32'h30040000;
    out_ready_i = 1'b1;
    do_reset();
    step(4);
    check("out x1 value", out_o, 32'd5);
    check("out x1 valid", 32'(out_valid_o), 32'd1);

    // input stall then sign-extended capture
    clear_mem();
    mem[0] = 32'h20000002;
    mem[1] = e_out(5'd2);
    do_reset();
    step(1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (in_ready_o !== 1'b1 || imem_addr_o !== 8'd0) bad++;
      step(1);
    end
    check("input stall cycles bad", 32'(bad), 32'd0);
    in_data_i = 16'h8001; in_valid_i = 1'b1;
    step(1);
    in_valid_i = 1'b0;
    check("input pc advanced", 32'(imem_addr_o), 32'd1);
    check("input ready drops", 32'(in_ready_o), 32'd0);
    step(2);
    check("input x2 value", out_o, 32'hFFFF8001);

    // conditional branches at PC=0x10
    clear_mem();
    mem[0] = e_jmp(8'd4);
    mem[4] = 32'h4C001FC0;
    do_reset();
    step(4);
    check("beq back pc", 32'(imem_addr_o), 32'd2);
    mem[4] = e_br(5'b11001, 5'd0, 5'd0, 8'h02);
    do_reset();
    step(4);
    check("bne fallthrough pc", 32'(imem_addr_o), 32'd5);

    // back-to-back OUTPUTs with a blocked consumer
    clear_mem();
    mem[0] = e_const(5'd1, 32'd7);
    mem[1] = e_const(5'd2, 32'd9);
    mem[2] = e_out(5'd1);
    mem[3] = e_out(5'd2);
    out_ready_i = 1'b0;
    do_reset();
    step(10);
    check("bp out held", out_o, 32'd7);
    check("bp valid", 32'(out_valid_o), 32'd1);
    check("bp stalled addr", 32'(imem_addr_o), 32'd3);
    step(3);
    check("bp still stalled", 32'(imem_addr_o), 32'd3);
    out_ready_i = 1'b1;
    step(1);
    out_ready_i = 1'b0;
    check("bp second out", out_o, 32'd9);
    check("bp valid kept", 32'(out_valid_o), 32'd1);
    check("bp pc advanced", 32'(imem_addr_o), 32'd4);
    step(3);
    check("bp halted", 32'(halted_o), 32'd1);
    check("bp out stable in halt", out_o, 32'd9);
    out_ready_i = 1'b1;
    step(1);
    check("bp drained in halt", 32'(out_valid_o), 32'd0);

    // HALT at PC=0x0C stays frozen until reset
    clear_mem();
    mem[0] = e_jmp(8'd3);
    do_reset();
    step(4);
    check("halt flag", 32'(halted_o), 32'd1);
    check("halt addr", 32'(imem_addr_o), 32'd3);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (halted_o !== 1'b1 || imem_addr_o !== 8'd3) bad++;
    end
    check("halt frozen cycles bad", 32'(bad), 32'd0);
    rst_i = 1'b1;
    step(1);
    check("halt reset flag", 32'(halted_o), 32'd0);
    check("halt reset addr", 32'(imem_addr_o), 32'd0);
    rst_i = 1'b0;

    // reset during an input stall discards the pending input
    clear_mem();
    mem[0] = e_const(5'd2, 32'h123);
    do_reset();
    step(4);
    check("preload halted", 32'(halted_o), 32'd1);
    mem[0] = e_in(5'd2);
    mem[1] = e_out(5'd2);
    do_reset();
    step(1);
    check("stall in_ready", 32'(in_ready_o), 32'd1);
    in_data_i = 16'h0055; in_valid_i = 1'b1; rst_i = 1'b1;
    step(1);
    check("rst stall in_ready", 32'(in_ready_o), 32'd0);
    check("rst stall addr", 32'(imem_addr_o), 32'd0);
    in_valid_i = 1'b0; rst_i = 1'b0;
    mem[0] = e_out(5'd2);
    mem[1] = 32'h8000_0000;
    out_ready_i = 1'b1;
    step(2);
    check("rst stall x2 kept", out_o, 32'h123);
    check("rst stall out valid", 32'(out_valid_o), 32'd1);
    out_ready_i = 1'b0;

    // ALU vector table, result via OUTPUT and flag via a branch
    for (int v = 0; v < 17; v++) begin
      clear_mem();
      mem[0] = e_const(5'd1, vt[v].a);
      mem[1] = e_const(5'd2, vt[v].b);
      mem[2] = e_alu(vt[v].op, 5'd1, 5'd2, 5'd3);
      mem[3] = e_out(5'd3);
      mem[4] = e_br(vt[v].op, 5'd1, 5'd2, 8'd3);
      mem[5] = e_const(5'd4, 32'd0);
      mem[6] = e_jmp(8'd2);
      mem[7] = e_const(5'd4, 32'd1);
      mem[8] = e_out(5'd4);
      run_prog({"alu ", vt[v].name}, 9);
      check({"alu ", vt[v].name, " count"}, 32'(got_q.size()), 32'd2);
      if (got_q.size() == 2) begin
        check({"alu ", vt[v].name, " result"}, got_q[0], vt[v].res);
        check({"alu ", vt[v].name, " flag"}, got_q[1], {31'd0, vt[v].flag});
      end
    end

    // random programs against the reference interpreter
    for (int t = 0; t < 6; t++) begin
      clear_mem();
      idx = 0;
      for (int r = 1; r < 8; r++) begin
        mem[idx] = e_const(5'(r), $urandom);
        idx++;
      end
      for (int i = 0; i < 20; i++) begin
        case ($urandom_range(0, 5))
          0: prog_word = e_const(5'($urandom_range(0, 7)), $urandom);
          1: prog_word = e_alu(ops[$urandom_range(0, 15)], 5'($urandom_range(0, 7)),
                               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
          2: prog_word = e_in(5'($urandom_range(0, 7)));
          3: prog_word = e_out(5'($urandom_range(0, 7)));
          4: prog_word = e_br(ops[$urandom_range(0, 15)], 5'($urandom_range(0, 7)),
                              5'($urandom_range(0, 7)), 8'($urandom_range(1, 3)));
          default: prog_word = e_jmp(8'($urandom_range(1, 3)));
        endcase
        mem[idx] = prog_word;
        idx++;
      end
      for (int r = 1; r < 8; r++) begin
        mem[idx] = e_out(5'(r));
        idx++;
      end
      run_prog($sformatf("rand%0d", t), idx);
      model_run(used_in);
      check($sformatf("rand%0d inputs used", t), 32'(used_in), 32'(in_q.size()));
      check($sformatf("rand%0d out count", t), 32'(got_q.size()), 32'(exp_q.size()));
      nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < nmin; i++) begin
        check($sformatf("rand%0d out[%0d]", t, i), got_q[i], exp_q[i]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cybercobra_mc.md
CYBERCOBRA_MC -- requirements
Module: cybercobra_mc

Interface
REQ-001 The block SHALL have parameter IN_W, default 16, giving the input-port data width (1..32), sign-extended to 32 bits.
REQ-002 The block SHALL have parameter ADDR_W, default 8, giving the instruction-memory word-address width; the program counter (PC) is ADDR_W+2 bits wide.
REQ-003 The block SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port imem_addr_o  output  ADDR_W  word address, equal to PC[ADDR_W+1:2].
REQ-006 The block SHALL have port imem_rdata_i  input  32  instruction word, valid one cycle after imem_addr_o (synchronous-read memory).
REQ-007 The block SHALL have ports in_data_i (input, IN_W), in_valid_i (input, 1) and in_ready_o (output, 1), forming the input-port valid/ready channel.
REQ-008 The block SHALL have ports out_o (output, 32), out_valid_o (output, 1) and out_ready_i (input, 1), forming the output-port valid/ready channel.
REQ-009 The block SHALL have port halted_o  output  1  high once a HALT instruction has executed.

Function
REQ-010 The instruction fields SHALL be: J=[31], B=[30], WS=[29:28], ALUOP=[27:23], RA1=[22:18], RA2=[17:13], OFFS=[12:5], WA=[4:0], CONST=sext(instr[27:5]).
REQ-011 The register file SHALL be 32x32 with two combinational reads and one synchronous write; register 0 always reads 0 and ignores writes; it is not reset.
REQ-012 The ALU SHALL be the team's alu_riscv with RD1/RD2 operands and op encodings ADD 00000, SUB 01000, EQ 11000, NE 11001, LTS 11100 (full set per alu_riscv), producing result and flag.
REQ-013 The FSM SHALL have three states: FETCH, EXEC and HALT; FETCH always goes to EXEC after 1 cycle; the instruction is sampled from imem_rdata_i in EXEC.
REQ-014 When J=0 and B=0, EXEC SHALL write back: WS=0 writes CONST, WS=1 writes the ALU result, WS=2 writes sext(in_data_i), WS=3 writes no register and issues an OUTPUT of RD1.
REQ-015 The branch SHALL be taken when J | (B & flag); taken sets PC <= PC + sext(OFFS)*4, otherwise PC <= PC + 4, both modulo 2^(ADDR_W+2).
REQ-016 An instruction with J=1 and OFFS=0 SHALL be a HALT: EXEC goes to HALT, halted_o=1, and PC is frozen until rst_i.
REQ-017 For an input instruction (WS=2), in_ready_o SHALL be 1 only in EXEC; EXEC stalls (no writeback, PC unchanged) until in_valid_i=1, then writes, advances the PC and goes to FETCH.
REQ-018 For an OUTPUT instruction, when out_valid_o=0 or out_ready_i=1 the block SHALL load out_o<=RD1, set out_valid_o<=1, advance the PC and go to FETCH; otherwise EXEC stalls.
REQ-019 out_valid_o SHALL clear on an out_ready_i handshake unless the same cycle loads a new OUTPUT, in which case it stays 1; out_o is stable while out_valid_o=1 and out_ready_i=0.
REQ-020 All other EXEC cases SHALL complete in 1 cycle, giving a CPI of 2 (FETCH + EXEC) without stalls.
REQ-021 In HALT, in_ready_o SHALL be 0; the output channel continues to drain, and no register writes occur.

Reset
REQ-022 On rst_i=1 at a clock edge the block SHALL set PC=0, state=FETCH, out_o=0, out_valid_o=0, halted_o=0 and in_ready_o=0, aborting any stall without writeback.
REQ-023 rst_i SHALL take priority over every handshake in the same cycle.

Verification
REQ-024 The bench SHALL cover: mem[0]=0x000000A1 (x1<=5), mem[1]=0x30040000 (OUTPUT x1), out_ready_i=1 -> out_o=5 with out_valid_o=1 after cycle 4 post-reset.
REQ-025 The bench SHALL cover: mem[0]=0x20000002 with in_valid_i=0 for 5 cycles -> in_ready_o=1, imem_addr_o=0 held; then in_data_i=16'h8001 with in_valid_i=1 -> x2=0xFFFF8001 and PC=4.
REQ-026 The bench SHALL cover: instruction 0x4C001FC0 (B, EQ x0,x0, OFFS=-2) at PC=0x10 -> next PC=0x08; with OFFS=0x02 and op NE -> next PC=0x14.
REQ-027 The bench SHALL cover: two back-to-back OUTPUTs of 7 then 9 with out_ready_i=0 -> out_o=7 held and the core stalled; raising out_ready_i for 1 cycle -> out_o=9 with out_valid_o still 1.
REQ-028 The bench SHALL cover: 0x80000000 at PC=0x0C -> halted_o=1 and imem_addr_o=3 frozen for 20 cycles; then rst_i -> PC=0 and halted_o=0.
REQ-029 The bench SHALL cover: rst_i asserted during an input stall -> no register write, in_ready_o=0 on the next cycle, and fetch restarts at address 0.
